// File: rtl/real_top_div_pkg.sv
// Shared types and sizing helpers for the real_top signed-by-unsigned sequential divider.
package real_top_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DIN0_WIDTH_DEF = 8;

    // The counter is loaded with din0_WIDTH itself, so it needs one extra code point.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIN0_WIDTH_DEF);

endpackage

// File: rtl/real_top_div_signfix.sv
// Conditional two's-complement negate; passes the value through when i_neg is low.
module real_top_div_signfix #(
    parameter int W = 8
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;

endmodule

// File: rtl/real_top_div_8s_2ns_8_seq.sv
// Sequential signed/unsigned restoring divider, one quotient bit per cycle, ap_start/ap_done handshake.
// Optional `REAL_TOP_DIV_DBZ_FLAG_EN adds a sticky-until-next-accept divide-by-zero flag output.
module real_top_div_8s_2ns_8_seq
    import real_top_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = DIN0_WIDTH_DEF,
    parameter int din1_WIDTH = 2,
    parameter int dout_WIDTH = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem
`ifdef REAL_TOP_DIV_DBZ_FLAG_EN
    ,
    output logic                  dbz
`endif
);

    localparam int CW = cnt_width(din0_WIDTH);

    if (ID < 0 || dout_WIDTH != din0_WIDTH) begin : g_param_chk
        $error("real_top_div: dout_WIDTH must equal din0_WIDTH and ID must be non-negative");
    end

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [din0_WIDTH-1:0] r_mag;
    logic                  r_neg;
    logic [din1_WIDTH-1:0] r_div;
    logic [din1_WIDTH:0]   r_part;
    logic [dout_WIDTH-1:0] r_quo;
    logic                  r_done;
    logic [dout_WIDTH-1:0] r_dout;
    logic [din1_WIDTH:0]   r_rem;
`ifdef REAL_TOP_DIV_DBZ_FLAG_EN
    logic                  r_dbz;
`endif

    logic [din0_WIDTH-1:0] w_abs;
    logic [din1_WIDTH:0]   w_shift;
    logic [din1_WIDTH:0]   w_div_ext;
    logic                  w_ge;
    logic [din1_WIDTH:0]   w_diff;
    logic                  w_div_zero;
    logic [dout_WIDTH-1:0] w_qfix;
    logic [din1_WIDTH:0]   w_rfix;
    logic [dout_WIDTH-1:0] w_dbz_q;

    // |din0| as unsigned: -2^(W-1) maps to 2^(W-1), which still fits in W bits.
    real_top_div_signfix #(.W(din0_WIDTH)) u_abs (
        .i_neg (din0[din0_WIDTH-1]),
        .i_val (din0),
        .o_val (w_abs)
    );

    real_top_div_signfix #(.W(dout_WIDTH)) u_qfix (
        .i_neg (r_neg),
        .i_val (r_quo),
        .o_val (w_qfix)
    );

    real_top_div_signfix #(.W(din1_WIDTH + 1)) u_rfix (
        .i_neg (r_neg),
        .i_val (r_part),
        .o_val (w_rfix)
    );

    // Partial remainder stays below the divisor, so its top bit is zero before each shift.
    assign w_shift    = {r_part[din1_WIDTH-1:0], r_mag[din0_WIDTH-1]};
    assign w_div_ext  = {1'b0, r_div};
    assign w_ge       = (w_shift >= w_div_ext);
    assign w_diff     = w_shift - w_div_ext;
    assign w_div_zero = (r_div == '0);
    assign w_dbz_q    = {r_neg, {(dout_WIDTH-1){~r_neg}}};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mag   <= '0;
            r_neg   <= 1'b0;
            r_div   <= '0;
            r_part  <= '0;
            r_quo   <= '0;
            r_done  <= 1'b0;
            r_dout  <= '0;
            r_rem   <= '0;
`ifdef REAL_TOP_DIV_DBZ_FLAG_EN
            r_dbz   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ap_start) begin
                        r_mag   <= w_abs;
                        r_neg   <= din0[din0_WIDTH-1];
                        r_div   <= din1;
                        r_part  <= '0;
                        r_quo   <= '0;
                        r_cnt   <= CW'(din0_WIDTH);
`ifdef REAL_TOP_DIV_DBZ_FLAG_EN
                        r_dbz   <= 1'b0;
`endif
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_part <= w_ge ? w_diff : w_shift;
                    r_quo  <= {r_quo[dout_WIDTH-2:0], w_ge};
                    r_mag  <= r_mag << 1;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // Divide by zero saturates toward the dividend's sign; the loop result is discarded.
                    if (w_div_zero) begin
                        r_dout <= w_dbz_q;
                        r_rem  <= '0;
`ifdef REAL_TOP_DIV_DBZ_FLAG_EN
                        r_dbz  <= 1'b1;
`endif
                    end else begin
                        r_dout <= w_qfix;
                        r_rem  <= w_rfix;
                    end
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ap_idle  = (r_state == IDLE);
    assign ap_ready = ap_idle & ap_start;
    assign ap_done  = r_done;
    assign dout     = r_dout;
    assign rem      = r_rem;
`ifdef REAL_TOP_DIV_DBZ_FLAG_EN
    assign dbz      = r_dbz;
`endif

endmodule
